// File: rtl/unified_mem_responder_if.sv
// unified_mem_responder_if: request/response valid-ready bundle
// for the unified instruction/data memory port.
interface unified_mem_responder_if #(
   parameter int ADDR_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [ADDR_W-1:0] req_addr;
   logic [2:0]        req_func3;
   logic [31:0]       req_wdata;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [31:0]       rsp_rdata;
   logic              rsp_err;

   modport master (
      output req_valid, req_we, req_addr, req_func3, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_func3, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/unified_mem_responder.sv
// unified_mem_responder: one-outstanding load/store responder over a
// little-endian word store. MEM_ERR_CHECK_EN enables access fault checks.
module unified_mem_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2,
   parameter int ADDR_W      = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   unified_mem_responder_if.slave bus
);
   localparam int IDX_W = $clog2(DEPTH_WORDS);
   localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [2:0]        f3_q;
   logic [31:0]       wdata_q;
   logic [31:0]       rdata_q;
   logic              err_q;
   logic [31:0]       mem [DEPTH_WORDS];

   logic              accept;
   logic              enter_resp;
   logic              op_we;
   logic [ADDR_W-1:0] op_addr;
   logic [2:0]        op_f3;
   logic [31:0]       op_wdata;
   logic [IDX_W-1:0]  op_idx;
   logic [1:0]        op_lane;
   logic              is_b, is_h, is_bu, is_hu;
   logic              op_err;
   logic [3:0]        be;
   logic [31:0]       st_data;
   logic [31:0]       rd_word;
   logic [7:0]        byte_v;
   logic [15:0]       half_v;
   logic [31:0]       ld_val;

   assign accept         = bus.req_valid && (state_q == S_IDLE);
   assign bus.req_ready  = (state_q == S_IDLE);
   assign bus.rsp_valid  = (state_q == S_RESP);
   assign bus.rsp_rdata  = rdata_q;
   assign bus.rsp_err    = err_q;

   // Operands: live request when committing on the accept edge, else latched
   always_comb begin
      op_we    = we_q;
      op_addr  = addr_q;
      op_f3    = f3_q;
      op_wdata = wdata_q;
      if (state_q == S_IDLE) begin
         op_we    = bus.req_we;
         op_addr  = bus.req_addr;
         op_f3    = bus.req_func3;
         op_wdata = bus.req_wdata;
      end
   end

   assign op_idx  = op_addr[IDX_W+1:2];
   assign op_lane = op_addr[1:0];
   assign is_b    = (op_f3 == 3'b000);
   assign is_h    = (op_f3 == 3'b001);
   assign is_bu   = (op_f3 == 3'b100);
   assign is_hu   = (op_f3 == 3'b101);

`ifdef MEM_ERR_CHECK_EN
   localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(4 * DEPTH_WORDS);

   // Faulting accesses complete normally but write nothing and return 0
   always_comb begin
      op_err = 1'b0;
      if ((is_h || is_hu) && op_addr[0])
         op_err = 1'b1;
      if ((op_f3 == 3'b010) && (op_lane != 2'b00))
         op_err = 1'b1;
      if ({1'b0, op_addr} >= ADDR_LIMIT)
         op_err = 1'b1;
      if ((op_f3 == 3'b011) || (op_f3 == 3'b110) || (op_f3 == 3'b111))
         op_err = 1'b1;
      if (op_we && (is_bu || is_hu))
         op_err = 1'b1;
   end
`else
   logic unused_addr;

   assign op_err      = 1'b0;
   assign unused_addr = ^op_addr;
`endif

   // Byte enables and lane-replicated store data
   always_comb begin
      be      = 4'b1111;
      st_data = op_wdata;
      unique case (1'b1)
         (is_b || is_bu): begin
            be      = 4'b0001 << op_lane;
            st_data = {4{op_wdata[7:0]}};
         end
         (is_h || is_hu): begin
            be      = op_lane[1] ? 4'b1100 : 4'b0011;
            st_data = {2{op_wdata[15:0]}};
         end
         default: be = 4'b1111;
      endcase
      if (!op_we || op_err)
         be = 4'b0000;
   end

   assign rd_word = mem[op_idx];
   assign byte_v  = rd_word[{op_lane, 3'b000} +: 8];
   assign half_v  = op_lane[1] ? rd_word[31:16] : rd_word[15:0];

   // Load extension by access size and signedness
   always_comb begin
      ld_val = rd_word;
      unique case (1'b1)
         is_b:    ld_val = {{24{byte_v[7]}}, byte_v};
         is_bu:   ld_val = {24'h0, byte_v};
         is_h:    ld_val = {{16{half_v[15]}}, half_v};
         is_hu:   ld_val = {16'h0, half_v};
         default: ld_val = rd_word;
      endcase
   end

   // Next-state: IDLE -> WAIT -> RESP -> IDLE
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:
            if (accept)
               state_d = (LATENCY == 1) ? S_RESP : S_WAIT;
         S_WAIT:
            if (cnt_q == CNT_W'(1))
               state_d = S_RESP;
         S_RESP:
            if (bus.rsp_ready)
               state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign enter_resp = (state_q != S_RESP) && (state_d == S_RESP);

   // State register and latency countdown
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         if (accept)
            cnt_q <= CNT_W'(LATENCY - 1);
         else if (state_q == S_WAIT)
            cnt_q <= cnt_q - CNT_W'(1);
      end
   end

   // Capture the accepted request
   always_ff @(posedge clk) begin
      if (accept) begin
         we_q    <= bus.req_we;
         addr_q  <= bus.req_addr;
         f3_q    <= bus.req_func3;
         wdata_q <= bus.req_wdata;
      end
   end

   // Response data captured as the response phase begins
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else if (enter_resp) begin
         rdata_q <= (op_we || op_err) ? 32'h0 : ld_val;
         err_q   <= op_err;
      end
   end

   // Byte-merged store commit; a reset on this edge drops it
   always_ff @(posedge clk) begin
      if (!rst && enter_resp) begin
         for (int i = 0; i < 4; i++)
            if (be[i])
               mem[op_idx][8*i +: 8] <= st_data[8*i +: 8];
      end
   end
endmodule

// File: tb/tb_unified_mem_responder.sv
// tb_unified_mem_responder: directed + random load/store traffic
// against a byte-array reference model.
module tb_unified_mem_responder;
   localparam int DEPTH = 1024;
   localparam int LAT   = 2;
   localparam int AW    = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   unified_mem_responder_if #(.ADDR_W(AW)) bus ();

   unified_mem_responder #(
      .DEPTH_WORDS(DEPTH),
      .LATENCY    (LAT),
      .ADDR_W     (AW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int checks = 0;
   int errors = 0;

   function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
      end
   endfunction

   function automatic void fail(string name);
      checks++;
      errors++;
      $display("FAIL %s: timed out (t=%0t)", name, $time);
   endfunction

   // Reference model state
   logic [7:0]  mb [4*DEPTH];
   int          cyc = 0;
   bit          live = 0;
   bit          pending = 0;
   bit          mdl_valid = 0;
   bit          fresh = 0;
   int          acc_cyc = 0;
   logic [31:0] exp_rd = '0;
   logic        exp_er = 1'b0;
   logic        st_we = 1'b0;
   logic [31:0] st_wd = '0;
   int          st_base = 0;
   int          st_off = 0;
   int          st_n = 0;

   function automatic void calc(
      input  logic        we,
      input  logic [31:0] a,
      input  logic [2:0]  f3,
      output logic [31:0] rd,
      output logic        er,
      output int          base,
      output int          off,
      output int          n
   );
      logic [31:0] v;
      bit          sgn;
      n    = (f3 == 0 || f3 == 4) ? 1 : (f3 == 1 || f3 == 5) ? 2 : 4;
      sgn  = (f3 == 0 || f3 == 1);
      off  = (n == 1) ? int'(a % 4) : (n == 2) ? int'((a / 2) % 2) * 2 : 0;
      base = int'(a % (4 * DEPTH)) - int'(a % 4);
      er   = 1'b0;
`ifdef MEM_ERR_CHECK_EN
      if (n == 2 && (a % 2) != 0) er = 1'b1;
      if (f3 == 2 && (a % 4) != 0) er = 1'b1;
      if (a >= 32'(4 * DEPTH)) er = 1'b1;
      if (f3 == 3 || f3 == 6 || f3 == 7) er = 1'b1;
      if (we && (f3 == 4 || f3 == 5)) er = 1'b1;
`endif
      v = 0;
      for (int i = 0; i < n; i++)
         v = v | (32'(mb[base + off + i]) << (8 * i));
      if (sgn && v[8*n-1])
         v = v | (32'hFFFF_FFFF << (8 * n));
      rd = (we || er) ? 32'h0 : v;
   endfunction

   // Model advances on each clock edge from the driven handshake signals
   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         pending = 0;
         fresh   = 1;
         live    = 1;
         exp_rd  = '0;
         exp_er  = 1'b0;
      end else if (pending && mdl_valid && bus.rsp_ready) begin
         if (st_we && !exp_er)
            for (int i = 0; i < st_n; i++)
               mb[st_base + st_off + i] = st_wd[8*i +: 8];
         pending = 0;
      end else if (!pending && bus.req_valid) begin
         calc(bus.req_we, bus.req_addr, bus.req_func3,
              exp_rd, exp_er, st_base, st_off, st_n);
         st_we   = bus.req_we;
         st_wd   = bus.req_wdata;
         pending = 1;
         fresh   = 0;
         acc_cyc = cyc;
      end
      mdl_valid = pending && (cyc >= acc_cyc + LAT - 1);
   end

   // Compare DUT outputs with the model every cycle
   always @(negedge clk) begin
      if (live) begin
         chk("req_ready", 32'(bus.req_ready), 32'(!pending));
         chk("rsp_valid", 32'(bus.rsp_valid), 32'(mdl_valid));
         if (mdl_valid || fresh) begin
            chk("rsp_rdata", bus.rsp_rdata, exp_rd);
            chk("rsp_err", 32'(bus.rsp_err), 32'(exp_er));
         end
      end
   end

   task automatic drive_req(input logic we, input logic [31:0] a,
                            input logic [2:0] f3, input logic [31:0] wd);
      bus.req_valid = 1'b1;
      bus.req_we    = we;
      bus.req_addr  = a;
      bus.req_func3 = f3;
      bus.req_wdata = wd;
   endtask

   task automatic wait_accept(output int acc);
      int n = 0;
      while (!bus.req_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!bus.req_ready)
         fail("accept");
      @(negedge clk);
      bus.req_valid = 1'b0;
      acc = cyc;
   endtask

   task automatic finish(input int hold, output logic [31:0] rd,
                         output logic er, output int lat_n, output int hs);
      int n = 0;
      while (!bus.rsp_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!bus.rsp_valid)
         fail("response");
      lat_n = n;
      repeat (hold) @(negedge clk);
      rd = bus.rsp_rdata;
      er = bus.rsp_err;
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      hs = cyc;
   endtask

   task automatic txn(input logic we, input logic [31:0] a, input logic [2:0] f3,
                      input logic [31:0] wd, input int hold,
                      output logic [31:0] rd, output logic er, output int lat_n);
      int acc, hs;
      drive_req(we, a, f3, wd);
      wait_accept(acc);
      finish(hold, rd, er, lat_n, hs);
   endtask

   initial begin
      logic [31:0] rd;
      logic        er;
      int          lat_n, acc, hs;

      bus.req_valid = 1'b0;
      bus.req_we    = 1'b0;
      bus.req_addr  = '0;
      bus.req_func3 = 3'b010;
      bus.req_wdata = '0;
      bus.rsp_ready = 1'b0;

      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
      chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);

      for (int w = 0; w < 16; w++)
         txn(1'b1, 32'(w * 4), 3'b010, $urandom, 0, rd, er, lat_n);

      txn(1'b1, 32'h10, 3'b010, 32'hDEADBEEF, 0, rd, er, lat_n);
      chk("sw_rdata", rd, 32'h0);
      txn(1'b0, 32'h10, 3'b010, 32'h0, 0, rd, er, lat_n);
      chk("lw10", rd, 32'hDEADBEEF);
      chk("lw10_latency", 32'(lat_n), 32'(LAT - 1));

      txn(1'b1, 32'h11, 3'b000, 32'h80, 0, rd, er, lat_n);
      txn(1'b0, 32'h11, 3'b000, 32'h0, 1, rd, er, lat_n);
      chk("lb11", rd, 32'hFFFF_FF80);
      txn(1'b0, 32'h11, 3'b100, 32'h0, 0, rd, er, lat_n);
      chk("lbu11", rd, 32'h0000_0080);
      txn(1'b0, 32'h10, 3'b010, 32'h0, 0, rd, er, lat_n);
      chk("lw10_sb", rd, 32'hDEAD80EF);

      txn(1'b0, 32'h12, 3'b001, 32'h0, 0, rd, er, lat_n);
      chk("lh12", rd, 32'hFFFF_DEAD);
      txn(1'b0, 32'h12, 3'b101, 32'h0, 0, rd, er, lat_n);
      chk("lhu12", rd, 32'h0000_DEAD);
      txn(1'b1, 32'h12, 3'b001, 32'h1234, 0, rd, er, lat_n);
      txn(1'b0, 32'h10, 3'b010, 32'h0, 0, rd, er, lat_n);
      chk("lw10_sh", rd, 32'h123480EF);

      // Backpressure with the next request held high throughout
      drive_req(1'b0, 32'h10, 3'b010, 32'h0);
      wait_accept(acc);
      drive_req(1'b0, 32'h11, 3'b100, 32'h0);
      finish(5, rd, er, lat_n, hs);
      chk("bp_rdata", rd, 32'h123480EF);
      wait_accept(acc);
      chk("bp_next_accept", 32'(acc - hs), 32'd1);
      finish(0, rd, er, lat_n, hs);
      chk("bp_next_rdata", rd, 32'h0000_0080);

      // Reset while the store waits: it must not land
      txn(1'b1, 32'h20, 3'b010, 32'h1122_3344, 0, rd, er, lat_n);
      drive_req(1'b1, 32'h20, 3'b010, 32'hAAAA_AAAA);
      wait_accept(acc);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("mid_rst_rdata", bus.rsp_rdata, 32'h0);
      txn(1'b0, 32'h20, 3'b010, 32'h0, 0, rd, er, lat_n);
      chk("lw20_dropped", rd, 32'h1122_3344);
      txn(1'b0, 32'h22, 3'b010, 32'h0, 0, rd, er, lat_n);
`ifdef MEM_ERR_CHECK_EN
      chk("lw22_err", 32'(er), 32'd1);
      chk("lw22_rdata", rd, 32'h0);
`else
      chk("lw22_err", 32'(er), 32'd0);
      chk("lw22_rdata", rd, 32'h1122_3344);
`endif

      for (int t = 0; t < 300; t++) begin
         logic [31:0] a;
         a = 32'($urandom_range(0, 63));
         if ($urandom_range(0, 3) == 0)
            a = a | (32'($urandom_range(1, 255)) << 12);
         repeat ($urandom_range(0, 2)) @(negedge clk);
         txn(1'($urandom_range(0, 1)), a, 3'($urandom_range(0, 7)),
             $urandom, $urandom_range(0, 3), rd, er, lat_n);
      end

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
